uart_cmd_assembler: RTL and testbench

//   Consumes bytes from UART_rcv (rx_data/rx_rdy) and assembles them MSB-first into
//   one NUM_BYTES-wide command word for the command-processing logic. Acknowledges

---
 rtl/uart_pkg.sv | 13 +
 rtl/uart_tmo_timer.sv | 29 ++
 rtl/uart_cmd_assembler.sv | 109 ++++++++++
 tb/tb_uart_cmd_assembler.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared types and UART timing constants for the command assembler.
// Exports asm_state_t, BAUD_DIV and BYTE_CYC.
package uart_pkg;

  typedef enum logic {
    IDLE,
    COLLECT
  } asm_state_t;

  localparam int BAUD_DIV = 2604;
  localparam int BYTE_CYC = 10 * BAUD_DIV;

endpackage

// File: rtl/uart_tmo_timer.sv
// Inter-byte timer: 16-bit saturating counter, flags the last cycle.
// Ports: clk, rst_n, clr, en in; expired out (tmr == CNT-1).
module uart_tmo_timer #(
  parameter int CNT = 52080
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [15:0] LAST = 16'(CNT - 1);

  logic [15:0] tmr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmr <= '0;
    end else if (clr) begin
      tmr <= '0;
    end else if (en && tmr != 16'hFFFF) begin
      tmr <= tmr + 16'd1;
    end
  end

  assign expired = (tmr == LAST);

endmodule

// File: rtl/uart_cmd_assembler.sv
// Packs UART bytes MSB-first into a NUM_BYTES command word.
// Ports: clk, rst_n, rx_rdy, rx_data, clr_cmd_rdy in;
// clr_rx_rdy, cmd, cmd_rdy, cmd_ovr, tmo out.
// `CMD_TIMEOUT_EN builds the inter-byte timeout (tmo tied to 0 otherwise).
module uart_cmd_assembler
  import uart_pkg::*;
#(
  parameter int NUM_BYTES = 2,
  parameter int TMO_CYC   = 2 * BYTE_CYC
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   rx_rdy,
  input  logic [7:0]             rx_data,
  output logic                   clr_rx_rdy,
  output logic [8*NUM_BYTES-1:0] cmd,
  output logic                   cmd_rdy,
  input  logic                   clr_cmd_rdy,
  output logic                   cmd_ovr,
  output logic                   tmo
);

  localparam int CMD_W = 8 * NUM_BYTES;
  localparam int CNT_W = $clog2(NUM_BYTES + 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_BYTES - 1);

  if (NUM_BYTES < 1 || NUM_BYTES > 4) begin : g_bad_nb
    $error("NUM_BYTES must be 1..4");
  end
  if (TMO_CYC < 1 || TMO_CYC > 65536) begin : g_bad_tmo
    $error("TMO_CYC must fit the 16-bit timer");
  end

  asm_state_t       state;
  logic [CNT_W-1:0] byte_cnt;
  logic [CMD_W-1:0] shreg;
  logic             last;
  logic             tmo_hit;

  // Mealy ack, gated so UART_rcv sees no clear while in reset.
  assign clr_rx_rdy = rx_rdy & rst_n;
  assign last       = (byte_cnt == LAST_CNT);

`ifdef CMD_TIMEOUT_EN
  logic expired;
  logic tmo_q;

  uart_tmo_timer #(
    .CNT(TMO_CYC)
  ) u_tmr (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (rx_rdy || state == IDLE),
    .en     (state == COLLECT),
    .expired(expired)
  );

  // An arriving byte beats a simultaneous expiry.
  assign tmo_hit = (state == COLLECT) && !rx_rdy && expired;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tmo_q <= 1'b0;
    end else begin
      tmo_q <= tmo_hit;
    end
  end

  assign tmo = tmo_q;
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      byte_cnt <= '0;
      shreg    <= '0;
      cmd      <= '0;
      cmd_rdy  <= 1'b0;
      cmd_ovr  <= 1'b0;
    end else begin
      cmd_ovr <= 1'b0;
      if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
      if (rx_rdy) begin
        shreg <= CMD_W'({shreg, rx_data});
        if (last) begin
          // Completion overrides a same-cycle consumer ack.
          cmd      <= CMD_W'({shreg, rx_data});
          cmd_rdy  <= 1'b1;
          cmd_ovr  <= cmd_rdy;
          byte_cnt <= '0;
          state    <= IDLE;
        end else begin
          byte_cnt <= byte_cnt + CNT_W'(1);
          state    <= COLLECT;
        end
      end else if (tmo_hit) begin
        state    <= IDLE;
        byte_cnt <= '0;
        shreg    <= '0;
      end
    end
  end

endmodule

// File: tb/tb_uart_cmd_assembler.sv
// Self-checking bench for uart_cmd_assembler (NUM_BYTES=2).
// Byte-queue reference model; directed steps then random traffic.
module tb_uart_cmd_assembler;

  localparam int NB  = 2;
  localparam int TMO = 52080;
  localparam int CW  = 8 * NB;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          rx_rdy = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          clr_rx_rdy;
  logic [CW-1:0] cmd;
  logic          cmd_rdy;
  logic          clr_cmd_rdy = 1'b0;
  logic          cmd_ovr;
  logic          tmo;

  uart_cmd_assembler #(
    .NUM_BYTES(NB),
    .TMO_CYC  (TMO)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .rx_rdy     (rx_rdy),
    .rx_data    (rx_data),
    .clr_rx_rdy (clr_rx_rdy),
    .cmd        (cmd),
    .cmd_rdy    (cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .cmd_ovr    (cmd_ovr),
    .tmo        (tmo)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [7:0]    part[$];
  logic [CW-1:0] m_cmd = '0;
  logic          m_rdy = 1'b0;
  logic          m_ovr = 1'b0;
  logic          m_tmo = 1'b0;
  int            idle_cnt = 0;
  int            tmo_pulses = 0;
  int            ovr_pulses = 0;

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    part.delete();
    m_cmd    = '0;
    m_rdy    = 1'b0;
    m_ovr    = 1'b0;
    m_tmo    = 1'b0;
    idle_cnt = 0;
  endtask

  // Called just after a negedge: drive, run one clock, check.
  task automatic step(input logic rdy, input logic [7:0] d,
                      input logic clr);
    logic          old_rdy;
    logic [CW-1:0] w;
    rx_rdy      = rdy;
    rx_data     = d;
    clr_cmd_rdy = clr;
    #1 check("clr_rx_rdy", 32'(clr_rx_rdy), 32'(rdy));
    @(negedge clk);
    rx_rdy      = 1'b0;
    clr_cmd_rdy = 1'b0;
    old_rdy = m_rdy;
    m_ovr   = 1'b0;
    m_tmo   = 1'b0;
    if (clr) m_rdy = 1'b0;
    if (rdy) begin
      idle_cnt = 0;
      part.push_back(d);
      if (part.size() == NB) begin
        w = '0;
        foreach (part[i]) w = (w << 8) | CW'(part[i]);
        m_cmd = w;
        m_ovr = old_rdy;
        m_rdy = 1'b1;
        part.delete();
      end
    end else begin
`ifdef CMD_TIMEOUT_EN
      if (part.size() > 0) begin
        idle_cnt++;
        if (idle_cnt == TMO) begin
          m_tmo = 1'b1;
          idle_cnt = 0;
          part.delete();
        end
      end
`endif
    end
    if (tmo === 1'b1) tmo_pulses++;
    if (cmd_ovr === 1'b1) ovr_pulses++;
    check("cmd", 32'(cmd), 32'(m_cmd));
    check("cmd_rdy", 32'(cmd_rdy), 32'(m_rdy));
    check("cmd_ovr", 32'(cmd_ovr), 32'(m_ovr));
    check("tmo", 32'(tmo), 32'(m_tmo));
  endtask

  task automatic send(input logic [7:0] b, input logic clr);
    step(1'b1, b, clr);
  endtask

  task automatic idle(input int n, input logic clr);
    for (int k = 0; k < n; k++) step(1'b0, 8'h00, clr);
  endtask

  initial begin
    logic [7:0] b;
    int         p0;

    // Reset state, with rx_rdy high to prove the ack is gated.
    rx_rdy = 1'b1;
    rx_data = 8'hEE;
    repeat (2) @(negedge clk);
    check("rst_clr_rx_rdy", 32'(clr_rx_rdy), 32'd0);
    check("rst_cmd", 32'(cmd), 32'd0);
    check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
    check("rst_cmd_ovr", 32'(cmd_ovr), 32'd0);
    check("rst_tmo", 32'(tmo), 32'd0);
    rx_rdy = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    @(negedge clk);

    // 1: basic frame, gap between bytes.
    send(8'hA5, 1'b0);
    idle(3, 1'b0);
    send(8'h3C, 1'b0);
    check("t1_cmd", 32'(cmd), 32'h0000A53C);
    check("t1_rdy", 32'(cmd_rdy), 32'd1);

    // 2: overrun, then consumer ack.
    p0 = ovr_pulses;
    send(8'h12, 1'b0);
    send(8'h34, 1'b0);
    check("t2_cmd", 32'(cmd), 32'h00001234);
    check("t2_ovr_pulses", 32'(ovr_pulses - p0), 32'd1);
    idle(2, 1'b0);
    idle(1, 1'b1);
    check("t2_rdy_clr", 32'(cmd_rdy), 32'd0);
    check("t2_cmd_hold", 32'(cmd), 32'h00001234);

    // 3: ack coincides with completion.
    send(8'h00, 1'b0);
    send(8'hFF, 1'b1);
    check("t3_rdy", 32'(cmd_rdy), 32'd1);
    check("t3_cmd", 32'(cmd), 32'h000000FF);
    idle(1, 1'b1);

    // 4: long stall after one byte.
    p0 = tmo_pulses;
    send(8'h55, 1'b0);
`ifdef CMD_TIMEOUT_EN
    idle(60000, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    check("t4_cmd", 32'(cmd), 32'h0000DEAD);
    check("t4_tmo_pulses", 32'(tmo_pulses - p0), 32'd1);
`else
    idle(200, 1'b0);
    send(8'hDE, 1'b0);
    send(8'hAD, 1'b0);
    check("t4_cmd", 32'(cmd), 32'h000055DE);
    check("t4_tmo_pulses", 32'(tmo_pulses - p0), 32'd0);
`endif

    // 5: reset mid-frame.
    idle(1, 1'b0);
    send(8'h77, 1'b0);
    rst_n   = 1'b0;
    rx_rdy  = 1'b1;
    rx_data = 8'h88;
    #1 check("t5_clr_in_rst", 32'(clr_rx_rdy), 32'd0);
    @(negedge clk);
    check("t5_rdy_in_rst", 32'(cmd_rdy), 32'd0);
    check("t5_cmd_in_rst", 32'(cmd), 32'd0);
    rx_rdy = 1'b0;
    rst_n  = 1'b1;
    model_reset();
    @(negedge clk);
    send(8'h01, 1'b0);
    send(8'h02, 1'b0);
    check("t5_cmd", 32'(cmd), 32'h00000102);

    // 6: sweep {i, ~i} with an ack after each command.
    idle(1, 1'b1);
    p0 = ovr_pulses;
    for (int i = 0; i < 256; i++) begin
      b = 8'(i);
      send(b, 1'b0);
      send(~b, 1'b0);
      check("t6_cmd", 32'(cmd), 32'({b, ~b}));
      idle(1, 1'b1);
    end
    check("t6_no_ovr", 32'(ovr_pulses - p0), 32'd0);

    // Random traffic with random acks and short gaps.
    for (int i = 0; i < 400; i++) begin
      step($urandom_range(0, 3) != 0, 8'($urandom),
           $urandom_range(0, 3) == 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
